// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds FSM states, the NOP word and fault codes.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  function automatic logic is_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory bus: valid/ready request, valid-only response.
// master = fetch controller, slave = memory.
interface imem_fetch_ctrl_if;
  logic        mem_req_valid;
  logic [29:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface

// File: rtl/imem_fetch_ctrl_timer.sv
// 16-bit saturating wait timer for the fetch controller.
// expired is high while count equals the configured limit.
module fetch_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: PC -> imem request -> decode handshake.
// Handles flushes, misaligned PCs and memory timeouts.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_addr,
  input  logic               pc_valid,
  input  logic               flush,
  output logic               pc_stall,
  output logic [31:0]        inst,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [1:0]         fault_cause,
  imem_fetch_ctrl_if.master  mem
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic        flush_pend;
  logic        req_valid_q;
  logic [29:0] req_addr_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic [1:0]  fault_q;

  logic tmr_clr;
  logic tmr_en;
  logic expired;

  fetch_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pc_valid && !flush) begin
          state_d = is_aligned(pc_addr) ? REQ : HOLD;
        end
      end
      REQ: begin
        // request is never retracted; a flush only redirects to DRAIN
        if (mem.mem_req_ready) begin
          state_d = (flush || flush_pend) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = mem.mem_rsp_valid ? IDLE : DRAIN;
        end else if (mem.mem_rsp_valid || expired) begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (mem.mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush || inst_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_stall = !(state_q == HOLD && inst_ready && !flush);
    tmr_en   = (state_q == WAIT);
    tmr_clr  = (state_q != WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pend   <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= FAULT_NONE;
    end else begin
      req_valid_q  <= (state_d == REQ);
      inst_valid_q <= (state_d == HOLD);
      flush_pend   <= (state_q == REQ) && !mem.mem_req_ready
                    && (flush_pend || flush);
      if (state_q == IDLE && state_d == REQ) begin
        req_addr_q <= pc_addr[31:2];
      end
      if (state_q == IDLE && state_d == HOLD) begin
        inst_q  <= NOP;
        fault_q <= FAULT_MISALIGN;
      end
      if (state_q == WAIT && state_d == HOLD) begin
        inst_q  <= mem.mem_rsp_valid ? mem.mem_rsp_data : NOP;
        fault_q <= mem.mem_rsp_valid ? FAULT_NONE : FAULT_TIMEOUT;
      end
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign inst              = inst_q;
  assign inst_valid        = inst_valid_q;
  assign fault_cause       = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: vector table, corner sequences,
// and randomized fetches against a behavioural memory and model.
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        flush;
  logic        pc_stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  fault_cause;

  imem_fetch_ctrl_if mif ();

  imem_fetch_ctrl #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .pc_stall    (pc_stall),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fault_cause (fault_cause),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memdata(logic [29:0] w);
    if (w == 30'h40) return 32'h00A0_0093;
    if (w == 30'h60) return 32'hDEAD_BEEF;
    return {w, 2'b11} ^ 32'h5A3C_9617;
  endfunction

  // memory responder configuration
  int          rdy_delay = 0;
  int          rsp_lat = 1;
  bit          never = 0;
  int          rdy_cnt;
  int          lat_cnt;
  bit          pending;
  bit          hs;
  logic [29:0] hs_addr;

  initial begin
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data  = '0;
    pending = 0; hs = 0; rdy_cnt = 0; lat_cnt = 0; hs_addr = '0;
    forever begin
      @(posedge clk); #1;
      mif.mem_rsp_valid = 1'b0;
      if (reset) begin
        pending = 0; hs = 0; rdy_cnt = 0;
        mif.mem_req_ready = 1'b0;
        continue;
      end
      if (hs) begin
        pending = 1; lat_cnt = rsp_lat - 1; rdy_cnt = 0;
      end
      if (pending && !never) begin
        if (lat_cnt == 0) begin
          mif.mem_rsp_valid = 1'b1;
          mif.mem_rsp_data  = memdata(hs_addr);
          pending = 0;
        end else begin
          lat_cnt--;
        end
      end
      if (mif.mem_req_valid) begin
        if (rdy_cnt < rdy_delay) begin
          mif.mem_req_ready = 1'b0; rdy_cnt++;
        end else begin
          mif.mem_req_ready = 1'b1;
        end
      end else begin
        mif.mem_req_ready = 1'b0;
      end
      hs = mif.mem_req_valid && mif.mem_req_ready;
      if (hs) hs_addr = mif.mem_req_addr;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // spec-level outcome of one fetch
  task automatic model(input logic [31:0] pc, input int d, input int lat,
                       input bit nv, output logic [31:0] ei,
                       output logic [1:0] ef, output int ec);
    if (pc[1:0] != 2'b00) begin
      ei = NOP; ef = 2'b01; ec = 1;
    end else if (nv || lat - 1 > T) begin
      ei = NOP; ef = 2'b10; ec = 2 + d + T + 1;
    end else begin
      ei = memdata(pc[31:2]); ef = 2'b00; ec = 2 + d + lat;
    end
  endtask

  task automatic run_fetch(input string nm, input logic [31:0] pc,
                           input int d, input int lat, input bit nv,
                           input int acc, input logic [31:0] ei,
                           input logic [1:0] ef, input int ec);
    int cyc = 0;
    bit seen = 0, addr_bad = 0, stall_bad = 0, hold_bad = 0;
    logic [31:0] held;
    rdy_delay = d; rsp_lat = lat; never = nv;
    pc_addr = pc; pc_valid = 1'b1; inst_ready = 1'b0; flush = 1'b0;
    do begin
      step(); cyc++; pc_valid = 1'b0;
      if (mif.mem_req_valid) begin
        seen = 1;
        if (mif.mem_req_addr !== pc[31:2]) addr_bad = 1;
      end
      if (pc_stall !== 1'b1) stall_bad = 1;
    end while (!inst_valid && cyc < 60);
    check({nm, " latency"}, cyc, ec);
    check({nm, " inst"}, inst, ei);
    check({nm, " fault"}, {30'd0, fault_cause}, {30'd0, ef});
    check({nm, " req_seen"}, {31'd0, seen}, {31'd0, pc[1:0] == 2'b00});
    check({nm, " req_addr"}, {31'd0, addr_bad}, 32'd0);
    held = inst;
    for (int i = 0; i < acc; i++) begin
      step();
      if (inst_valid !== 1'b1 || inst !== held) hold_bad = 1;
      if (pc_stall !== 1'b1) stall_bad = 1;
    end
    check({nm, " hold"}, {31'd0, hold_bad}, 32'd0);
    check({nm, " stall"}, {31'd0, stall_bad}, 32'd0);
    inst_ready = 1'b1;
    #1 check({nm, " accept_stall"}, {31'd0, pc_stall}, 32'd0);
    step();
    inst_ready = 1'b0;
    check({nm, " release"}, {31'd0, inst_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    int          d;
    int          lat;
    bit          nv;
    int          acc;
    logic [31:0] ei;
    logic [1:0]  ef;
    int          ec;
  } vec_t;

  vec_t tbl [8];

  task automatic no_valid(input string nm, input int n);
    bit bad = 0;
    for (int i = 0; i < n; i++) begin
      if (inst_valid !== 1'b0) bad = 1;
      step();
    end
    check(nm, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc, ei;
    logic [1:0]  ef;
    int          d, lat, acc, ec;
    bit          nv;

    tbl[0] = '{32'h0000_0100, 0, 1,  0, 0, 32'h00A0_0093, 2'b00, 3};
    tbl[1] = '{32'h0000_0102, 0, 1,  0, 0, NOP, 2'b01, 1};
    tbl[2] = '{32'h0000_0104, 3, 1,  0, 4, memdata(30'h41), 2'b00, 6};
    tbl[3] = '{32'h0000_0108, 0, 4,  0, 1, memdata(30'h42), 2'b00, 6};
    tbl[4] = '{32'h0000_010C, 0, 1,  1, 0, NOP, 2'b10, 11};
    tbl[5] = '{32'h0000_0110, 1, 9,  0, 0, memdata(30'h44), 2'b00, 12};
    tbl[6] = '{32'h0000_0114, 0, 10, 0, 0, NOP, 2'b10, 11};
    tbl[7] = '{32'h0000_0003, 0, 1,  0, 2, NOP, 2'b01, 1};

    reset = 1'b1; pc_valid = 1'b0; flush = 1'b0;
    inst_ready = 1'b0; pc_addr = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst inst", inst, 32'd0);
    check("rst fault", {30'd0, fault_cause}, 32'd0);
    check("rst req_valid", {31'd0, mif.mem_req_valid}, 32'd0);
    check("rst req_addr", {2'd0, mif.mem_req_addr}, 32'd0);
    check("rst pc_stall", {31'd0, pc_stall}, 32'd1);
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      run_fetch($sformatf("vec%0d", i), tbl[i].pc, tbl[i].d, tbl[i].lat,
                tbl[i].nv, tbl[i].acc, tbl[i].ei, tbl[i].ef, tbl[i].ec);
    end

    // flush in WAIT, stale 0xDEADBEEF lands two cycles later
    rdy_delay = 0; rsp_lat = 3; never = 0;
    pc_addr = 32'h0000_0180; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    no_valid("flush_wait stale", 5);
    run_fetch("after_flush_wait", 32'h0000_0200, 0, 1, 0, 0,
              memdata(30'h80), 2'b00, 3);

    // flush seen in REQ under backpressure
    rdy_delay = 3; rsp_lat = 1;
    pc_addr = 32'h0000_01C0; pc_valid = 1'b1;
    step(); pc_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    no_valid("flush_req drain", 8);
    run_fetch("after_flush_req", 32'h0000_01C4, 0, 2, 0, 0,
              memdata(30'h71), 2'b00, 4);

    // flush together with the response: straight to IDLE
    rdy_delay = 0; rsp_lat = 1;
    pc_addr = 32'h0000_0280; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    no_valid("flush_rsp drop", 3);
    run_fetch("after_flush_rsp", 32'h0000_0284, 0, 1, 0, 0,
              memdata(30'hA1), 2'b00, 3);

    // flush beats inst_ready in HOLD
    pc_addr = 32'h0000_0240; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); step();
    check("flush_hold valid", {31'd0, inst_valid}, 32'd1);
    inst_ready = 1'b1; flush = 1'b1;
    #1 check("flush_hold stall", {31'd0, pc_stall}, 32'd1);
    step();
    flush = 1'b0; inst_ready = 1'b0;
    check("flush_hold drop", {31'd0, inst_valid}, 32'd0);
    step();

    // asynchronous reset while waiting on a silent memory
    never = 1'b1;
    pc_addr = 32'h0000_0300; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); step();
    #1 reset = 1'b1;
    #1;
    check("arst inst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst inst", inst, 32'd0);
    check("arst fault", {30'd0, fault_cause}, 32'd0);
    check("arst req_valid", {31'd0, mif.mem_req_valid}, 32'd0);
    check("arst req_addr", {2'd0, mif.mem_req_addr}, 32'd0);
    check("arst pc_stall", {31'd0, pc_stall}, 32'd1);
    step();
    reset = 1'b0; never = 1'b0;
    step();
    run_fetch("after_reset", 32'h0000_0304, 0, 1, 0, 0,
              memdata(30'hC1), 2'b00, 3);

    for (int n = 0; n < 40; n++) begin
      pc  = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      d   = $urandom_range(0, 3);
      lat = $urandom_range(1, 12);
      nv  = ($urandom_range(0, 7) == 0);
      acc = $urandom_range(0, 2);
      model(pc, d, lat, nv, ei, ef, ec);
      run_fetch($sformatf("rnd%0d", n), pc, d, lat, nv, acc, ei, ef, ec);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
